// File: rtl/piso_serializer.sv
// Parallel-in/serial-out stage: WIDTH-bit words over valid/ready become a gap-free
// one-bit-per-clock stream, with a one-word holding register for back-to-back input.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1,
    parameter bit          IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             data_out,
    output logic             out_valid,
    output logic             busy,
    output logic [15:0]      word_cnt
);

    localparam int unsigned CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             hold_full_q, hold_full_d;
    logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [15:0]      word_cnt_q, word_cnt_d;
    logic [WIDTH-1:0] shifted;
    logic             head;
    logic             xfer;

    generate
        if (MSB_FIRST) begin : g_msb
            assign head    = shift_q[WIDTH-1];
            assign shifted = {shift_q[WIDTH-2:0], 1'b0};
        end else begin : g_lsb
            assign head    = shift_q[0];
            assign shifted = {1'b0, shift_q[WIDTH-1:1]};
        end
    endgenerate

    assign in_ready  = !rst && !hold_full_q;
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state_q == SHIFT);
    assign data_out  = (state_q == SHIFT) ? head : IDLE_BIT;
    assign busy      = (state_q == SHIFT) || hold_full_q;
    assign word_cnt  = word_cnt_q;

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        bit_cnt_d   = bit_cnt_q;
        word_cnt_d  = word_cnt_q;
        case (state_q)
            IDLE: begin
                if (xfer) begin
                    shift_d   = in_data;
                    bit_cnt_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_cnt_q != LAST) begin
                    shift_d   = shifted;
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (xfer) begin
                        hold_d      = in_data;
                        hold_full_d = 1'b1;
                    end
                end else begin
                    // Last bit: reload from hold or a direct transfer so the next word follows with no gap.
                    word_cnt_d = word_cnt_q + 16'd1;
                    bit_cnt_d  = '0;
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                    end else if (xfer) begin
                        shift_d = in_data;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            bit_cnt_q   <= '0;
            word_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            bit_cnt_q   <= bit_cnt_d;
            word_cnt_q  <= word_cnt_d;
        end
    end

endmodule

// File: doc/piso_serializer.md
Name: piso_serializer

Overview:
- Parallel-in/serial-out stage that sits directly upstream of the 1011 sequence detector.
- Accepts WIDTH-bit words over a valid/ready handshake and emits them as a continuous one-bit-per-clock stream (data_out + out_valid) that drives the detector's data_in.
- A one-word holding register allows back-to-back words with zero gap bits, so patterns spanning word boundaries reach the detector intact.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..32.
- MSB_FIRST, 1: 1 = bit WIDTH-1 is sent first; 0 = bit 0 is sent first.
- IDLE_BIT, 0: value driven on data_out whenever out_valid = 0.

Ports:
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_data, input, WIDTH: parallel word.
- in_valid, input, 1: in_data is valid.
- in_ready, output, 1: block can accept a word this cycle.
- data_out, output, 1: serial bit (feeds detector data_in).
- out_valid, output, 1: data_out carries a real data bit.
- busy, output, 1: shifter active OR holding register full.
- word_cnt, output, 16: count of fully transmitted words; wraps 0xFFFF -> 0x0000.

Behaviour:
- Reset (rst = 1 at a clock edge): state = IDLE, hold empty, bit_cnt = 0, word_cnt = 0, out_valid = 0, data_out = IDLE_BIT, busy = 0.
  - in_ready is forced to 0 while rst is high.
  - Reset mid-word abandons the word; no partial bits follow, and word_cnt is not incremented for it.
- Handshake: transfer occurs when in_valid && in_ready at a rising edge.
  - in_ready = !rst && !hold_full (combinational).
  - in_data is sampled only on transfer. in_valid may drop without a transfer; no requirement to hold it.
- State machine: two states, IDLE and SHIFT.
  - IDLE, transfer: load the shifter directly from in_data, bit_cnt = 0, go to SHIFT. The first bit appears on data_out in the cycle immediately after the accepting edge (latency 1 clock). Hold stays empty.
  - SHIFT, bit_cnt < WIDTH-1: shift one position, bit_cnt++. A transfer in this cycle loads the holding register.
  - SHIFT, bit_cnt == WIDTH-1 (last bit), at the edge: word_cnt++. Then:
    - hold full: move hold into shifter, hold empties, bit_cnt = 0, stay in SHIFT. A simultaneous transfer is impossible because in_ready = 0.
    - hold empty with a simultaneous transfer: load in_data directly into shifter, stay in SHIFT.
    - otherwise: go to IDLE.
    - In all continuing cases, the next word's first bit follows the previous last bit with no gap.
- Outputs:
  - out_valid = 1 exactly when state == SHIFT.
  - data_out = current shifter head bit (MSB or LSB per MSB_FIRST) when out_valid = 1, else IDLE_BIT.
  - Outputs are registered or derived purely from registered state; no combinational path from in_* to data_out or out_valid.
- Throughput: a sustained source gets in_ready high at least once per WIDTH cycles; stream occupancy is 100%.
- busy = (state == SHIFT) || hold_full.

Test Plan:
- Reset, then send 0x2D (MSB_FIRST = 1) with a single valid pulse.
  - Response: out_valid high for exactly 8 cycles starting one cycle after accept; data_out = 0,0,1,0,1,1,0,1; then out_valid = 0, data_out = 0; word_cnt = 1.
- Back-to-back 0x0B, 0x0B with in_valid held high.
  - Response: 16 contiguous valid bits 00001011 00001011; in_ready drops after the second accept while hold is full; word_cnt = 2.
  - The downstream 1011 Moore detector's det pulses twice, one cycle after each final "1".
- MSB_FIRST = 0, send 0xD0.
  - Response: data_out = 0,0,0,0,1,0,1,1.
  - Third word offered while hold is full is stalled (in_ready = 0) until the shifter's last-bit edge.
- rst asserted at bit 3 of a word with hold full.
  - Response: the next cycle shows out_valid = 0, data_out = IDLE_BIT, busy = 0, word_cnt = 0; in_ready = 0 during rst and 1 after.
  - A new word after reset serializes cleanly.
- Send 65537 words.
  - Response: word_cnt wraps to 0x0001; no bit gaps under continuous in_valid.
